// File: rtl/cpri_pkg.sv
// Shared CPRI chip-frame constants and TX framer types.
// The RX loop buffer uses the same word address map.
package cpri_pkg;

    localparam int CPRI_HEAD_FIRST = 3;
    localparam int CPRI_IQ_FIRST   = 7;
    localparam int CPRI_IQ_LAST    = 90;
    localparam int CPRI_FRAME_LEN  = 91;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    // The field order matches the concatenation {agc, shift, info} used at load time.
    typedef struct packed {
        logic [15:0]  agc;
        logic [63:0]  shift;
        logic [255:0] info;
    } cpri_hdr_t;

endpackage

// File: rtl/cpri_tx_iq_fifo.sv
// Synchronous IQ FIFO with a registered read port (1-cycle latency) and an occupancy count.
// Pushes are accepted only while ready; ready is a flop that tracks count < DEPTH.
module cpri_tx_iq_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic [CW-1:0]     count_nxt;

    assign push_ok   = push && ready;
    assign count_nxt = count + CW'(push_ok) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            ready <= (count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
        if (pop)     rdata <= mem[rd_ptr];
    end

endmodule

// File: rtl/cpri_tx_gen.sv
// Transmit-side CPRI chip framer: buffers IQ words and header info, then writes one
// 91-word chip (control, info, IQ) per start with a minimum idle gap between chips.
module cpri_tx_gen
    import cpri_pkg::*;
#(
    parameter int          IQ_WORDS   = 84,
    parameter int          FIFO_DEPTH = 256,
    parameter int          GAP_CYCLES = 4,
    parameter logic [31:0] SYNC_WORD  = 32'h5A5A_C3C3
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_tx_enable,
    input  logic         i_info_vld,
    input  logic [255:0] i_info,
    input  logic [15:0]  i_fft_agc,
    input  logic [63:0]  i_fft_shift,
    input  logic         i_iq_valid,
    input  logic [63:0]  i_iq_data,
    output logic         o_iq_ready,
    output logic         o_cpri_wen,
    output logic [6:0]   o_cpri_waddr,
    output logic [63:0]  o_cpri_wdata,
    output logic         o_cpri_wlast,
    output logic [15:0]  o_frame_seq,
    output logic         o_info_ovf
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [6:0]       addr_cnt;
    logic [7:0]       gap_cnt;
    logic             info_pend;
    cpri_hdr_t        hdr_pend;
    cpri_hdr_t        hdr_frame;
    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      fifo_rdata;
    logic             can_start;
    logic             start;
    logic             emit;
    logic             last_word;
    logic             fifo_pop;
    logic [6:0]       addr_nxt;
    logic [63:0]      word_nxt;

    cpri_tx_iq_fifo #(
        .DATA_W (64),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .push  (i_iq_valid),
        .wdata (i_iq_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .ready (o_iq_ready)
    );

    assign can_start = i_tx_enable && info_pend && (fifo_count >= CNT_W'(IQ_WORDS));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (can_start) state_nxt = SEND;
            SEND:    if (addr_cnt == 7'(CPRI_FRAME_LEN - 1)) state_nxt = GAP;
            GAP:     if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // addr_cnt is the word registered at the coming edge; pops lead by one for the FIFO read register.
    always_comb begin
        start     = 1'b0;
        emit      = 1'b0;
        last_word = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state)
            IDLE: begin
                start = can_start;
                emit  = can_start;
            end
            SEND: begin
                emit      = 1'b1;
                last_word = (addr_cnt == 7'(CPRI_FRAME_LEN - 1));
                fifo_pop  = (addr_cnt >= 7'(CPRI_IQ_FIRST - 1)) && (addr_cnt < 7'(CPRI_IQ_LAST));
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_nxt = addr_cnt;
        word_nxt = fifo_rdata;
        if (state == IDLE) begin
            addr_nxt = 7'd0;
            word_nxt = {SYNC_WORD, o_frame_seq + 16'd1, 16'h0};
        end else begin
            unique case (addr_cnt)
                7'd1:                        word_nxt = hdr_frame.shift;
                7'd2:                        word_nxt = {hdr_frame.agc, 48'h0};
                7'(CPRI_HEAD_FIRST):         word_nxt = hdr_frame.info[63:0];
                7'(CPRI_HEAD_FIRST + 1):     word_nxt = hdr_frame.info[127:64];
                7'(CPRI_HEAD_FIRST + 2):     word_nxt = hdr_frame.info[191:128];
                7'(CPRI_HEAD_FIRST + 3):     word_nxt = hdr_frame.info[255:192];
                default:                     word_nxt = fifo_rdata;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE:    addr_cnt <= start ? 7'd1 : 7'd0;
                SEND:    addr_cnt <= addr_cnt + 7'd1;
                default: addr_cnt <= '0;
            endcase
            gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

    // A strobe in the start cycle refills the pending slot for the next chip without overflow.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            info_pend   <= 1'b0;
            o_info_ovf  <= 1'b0;
            o_frame_seq <= '0;
        end else begin
            if (i_info_vld)  info_pend <= 1'b1;
            else if (start)  info_pend <= 1'b0;
            if (i_info_vld && info_pend && !start) o_info_ovf <= 1'b1;
            if (start) o_frame_seq <= o_frame_seq + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_info_vld) hdr_pend  <= {i_fft_agc, i_fft_shift, i_info};
        if (start)      hdr_frame <= hdr_pend;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cpri_wen   <= 1'b0;
            o_cpri_waddr <= '0;
            o_cpri_wdata <= '0;
            o_cpri_wlast <= 1'b0;
        end else begin
            o_cpri_wen   <= emit;
            o_cpri_waddr <= emit ? addr_nxt : 7'd0;
            o_cpri_wdata <= emit ? word_nxt : 64'd0;
            o_cpri_wlast <= last_word;
        end
    end

endmodule

// File: tb/tb_cpri_tx_gen.sv
// Scoreboard bench for cpri_tx_gen: stimulus pushes expected chip words into a queue,
// a negedge monitor pops and compares every word the framer writes.
module tb_cpri_tx_gen;

    localparam logic [31:0] SYNC = 32'h5A5A_C3C3;
    localparam int          GAP  = 4;
    localparam int          DEPTH = 256;

    logic         clk;
    logic         rst_n;
    logic         tx_enable;
    logic         info_vld;
    logic [255:0] info;
    logic [15:0]  fft_agc;
    logic [63:0]  fft_shift;
    logic         iq_valid;
    logic [63:0]  iq_data;
    logic         iq_ready;
    logic         cpri_wen;
    logic [6:0]   cpri_waddr;
    logic [63:0]  cpri_wdata;
    logic         cpri_wlast;
    logic [15:0]  frame_seq;
    logic         info_ovf;

    cpri_tx_gen dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_tx_enable  (tx_enable),
        .i_info_vld   (info_vld),
        .i_info       (info),
        .i_fft_agc    (fft_agc),
        .i_fft_shift  (fft_shift),
        .i_iq_valid   (iq_valid),
        .i_iq_data    (iq_data),
        .o_iq_ready   (iq_ready),
        .o_cpri_wen   (cpri_wen),
        .o_cpri_waddr (cpri_waddr),
        .o_cpri_wdata (cpri_wdata),
        .o_cpri_wlast (cpri_wlast),
        .o_frame_seq  (frame_seq),
        .o_info_ovf   (info_ovf)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [63:0] data;
        logic        last;
        logic [15:0] seq;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] iq_model[$];
    int          model_occ;
    logic [15:0] model_seq;
    logic [255:0] m_info;
    logic [15:0] m_agc;
    logic [63:0] m_shift;

    int n_checks, n_fail;
    int cyc;
    int frames_seen, frames_exp;
    int last_push_cyc, expect_addr0_cyc;
    int wlast_cyc, last_gap;
    bit have_wlast, in_frame;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: control words, four info words, then 84 IQ words in arrival order.
    task automatic expect_frame();
        exp_t e;
        model_seq++;
        for (int a = 0; a < 91; a++) begin
            e.addr = 7'(a);
            e.last = (a == 90);
            e.seq  = model_seq;
            if (a == 0)      e.data = {SYNC, model_seq, 16'h0};
            else if (a == 1) e.data = m_shift;
            else if (a == 2) e.data = {m_agc, 48'h0};
            else if (a < 7)  e.data = m_info[64*(a-3) +: 64];
            else             e.data = iq_model.pop_front();
            exp_q.push_back(e);
        end
        model_occ -= 84;
        frames_exp++;
    endtask

    task automatic send_info(input logic [255:0] i, input logic [15:0] a, input logic [63:0] s);
        @(negedge clk);
        info_vld = 1'b1; info = i; fft_agc = a; fft_shift = s;
        m_info = i; m_agc = a; m_shift = s;
        @(negedge clk);
        info_vld = 1'b0;
    endtask

    task automatic send_rand_info();
        send_info({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  16'($urandom), {$urandom, $urandom});
    endtask

    // mode 0: random words, mode 1: word value = index
    task automatic push_n(input int n, input int mode);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = (mode == 1) ? 64'(i) : {$urandom, $urandom};
            iq_valid = 1'b1; iq_data = d; last_push_cyc = cyc;
            if (model_occ < DEPTH) begin
                iq_model.push_back(d);
                model_occ++;
            end
        end
        @(negedge clk);
        iq_valid = 1'b0;
    endtask

    task automatic wait_starts();
        for (int i = 0; i < 400 && frames_seen < frames_exp; i++) @(negedge clk);
        chk("start_timeout", 64'(frames_seen), 64'(frames_exp));
    endtask

    task automatic wait_addr(input int a);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cpri_wen && cpri_waddr == 7'(a)) break;
        end
        chk("reach_addr", 64'(k < 400), 64'd1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpri_wen) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_wen: got addr %0d with no chip expected (cycle %0d)", cpri_waddr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", 64'(cpri_waddr), 64'(e.addr));
                    chk($sformatf("wdata@%0d", e.addr), cpri_wdata, e.data);
                    chk("wlast", 64'(cpri_wlast), 64'(e.last));
                    if (e.addr == 0) begin
                        frames_seen++;
                        chk("frame_seq", 64'(frame_seq), 64'(e.seq));
                        if (have_wlast) begin
                            last_gap = cyc - wlast_cyc - 1;
                            chk("gap_min", 64'(last_gap >= GAP), 64'd1);
                        end
                        if (expect_addr0_cyc != 0) begin
                            chk("addr0_latency", 64'(cyc), 64'(expect_addr0_cyc));
                            expect_addr0_cyc = 0;
                        end
                    end
                end
                in_frame = !cpri_wlast;
                if (cpri_wlast) begin
                    have_wlast = 1'b1;
                    wlast_cyc  = cyc;
                end
            end else if (in_frame) begin
                n_checks++; n_fail++;
                $display("FAIL wen_continuity: got wen 0 expected 1 (cycle %0d)", cyc);
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        int seen0;
        n_checks = 0; n_fail = 0;
        frames_seen = 0; frames_exp = 0;
        expect_addr0_cyc = 0; have_wlast = 1'b0; in_frame = 1'b0;
        model_occ = 0; model_seq = 16'd0;
        rst_n = 1'b0; tx_enable = 1'b1; info_vld = 1'b0; info = '0;
        fft_agc = '0; fft_shift = '0; iq_valid = 1'b0; iq_data = '0;

        repeat (3) @(negedge clk);
        chk("rst_wen", 64'(cpri_wen), 64'd0);
        chk("rst_waddr", 64'(cpri_waddr), 64'd0);
        chk("rst_wdata", cpri_wdata, 64'd0);
        chk("rst_wlast", 64'(cpri_wlast), 64'd0);
        chk("rst_seq", 64'(frame_seq), 64'd0);
        chk("rst_ovf", 64'(info_ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(iq_ready), 64'd1);

        // Single chip with known contents
        send_info({4{64'h1111_1111_1111_1111}}, 16'h00AB, 64'h5);
        push_n(84, 1);
        expect_frame();
        wait_starts();

        // 83 words are not enough; the 84th starts a chip two cycles later
        send_rand_info();
        push_n(83, 0);
        seen0 = frames_seen;
        repeat (40) @(negedge clk);
        chk("no_start_83", 64'(frames_seen), 64'(seen0));
        push_n(1, 0);
        expect_addr0_cyc = last_push_cyc + 2;
        expect_frame();
        wait_starts();

        // Back-to-back chips separated by the minimum gap
        push_n(252, 0);
        send_rand_info();
        expect_frame();
        wait_starts();
        for (int f = 0; f < 2; f++) begin
            send_rand_info();
            expect_frame();
            wait_starts();
            chk("b2b_gap", 64'(last_gap), 64'(GAP));
        end
        chk("ovf_clear", 64'(info_ovf), 64'd0);

        // Info overwrite: second strobe wins
        send_rand_info();
        send_rand_info();
        @(negedge clk);
        chk("ovf_set", 64'(info_ovf), 64'd1);
        push_n(84, 0);
        expect_frame();
        wait_starts();

        // Enable drop mid-chip: chip completes, no new start
        send_rand_info();
        push_n(84, 0);
        expect_frame();
        wait_addr(40);
        tx_enable = 1'b0;
        send_rand_info();
        seen0 = frames_seen;
        repeat (150) @(negedge clk);
        chk("no_start_disabled", 64'(frames_seen), 64'(seen0));
        chk("enable_drop_done", 64'(exp_q.size()), 64'd0);

        // Fill the FIFO; the extra word must be dropped
        push_n(256, 0);
        chk("full_ready", 64'(iq_ready), 64'd0);
        push_n(1, 0);
        chk("full_ready_hold", 64'(iq_ready), 64'd0);
        chk("model_occ", 64'(model_occ), 64'(DEPTH));
        tx_enable = 1'b1;
        expect_frame();
        wait_starts();
        for (int f = 0; f < 2; f++) begin
            send_rand_info();
            expect_frame();
            wait_starts();
        end
        push_n(80, 0);
        send_rand_info();
        expect_frame();
        wait_starts();

        // Reset in the middle of a chip
        send_rand_info();
        push_n(84, 0);
        expect_frame();
        wait_addr(50);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete(); iq_model.delete();
        in_frame = 1'b0; have_wlast = 1'b0;
        model_occ = 0; model_seq = 16'd0;
        chk("mid_rst_wen", 64'(cpri_wen), 64'd0);
        chk("mid_rst_waddr", 64'(cpri_waddr), 64'd0);
        chk("mid_rst_wdata", cpri_wdata, 64'd0);
        chk("mid_rst_wlast", 64'(cpri_wlast), 64'd0);
        chk("mid_rst_seq", 64'(frame_seq), 64'd0);
        chk("mid_rst_ovf", 64'(info_ovf), 64'd0);
        chk("mid_rst_count", 64'(dut.fifo_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_rst", 64'(iq_ready), 64'd1);
        send_rand_info();
        push_n(84, 0);
        expect_frame();
        wait_starts();

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
